// File: rtl/fetch_pc_gen_if.sv
// Instruction-side request/response bus between fetch and I-memory.
// master: issues inst_req/inst_addr; slave: answers addr_ok/data_ok/rdata.
interface fetch_pc_gen_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: issues I-side requests, tracks BTB predictions
// per in-flight pc, buffers returned instructions in a 2-entry FIFO.
// Ports: clk/reset, inst bus (master), BTB lookup/result, redirect,
// fs_* decode-side outputs with ds_allowin backpressure.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h1C000000
) (
  input  logic           clk,
  input  logic           reset,
  fetch_pc_gen_if.master inst,
  output logic           fetch_en,
  output logic [31:0]    fetch_pc,
  input  logic           btb_ret_en,
  input  logic           btb_taken,
  input  logic [31:0]    btb_ret_pc,
  input  logic [4:0]     btb_ret_index,
  input  logic           redirect,
  input  logic [31:0]    redirect_pc,
  output logic           fs_valid,
  output logic [31:0]    fs_pc,
  output logic [31:0]    fs_inst,
  output logic           fs_pred_en,
  output logic           fs_pred_taken,
  output logic [4:0]     fs_pred_index,
  output logic [31:0]    fs_pred_target,
  input  logic           ds_allowin
);

  typedef struct packed {
    logic [31:0] pc;
    logic        pred_en;
    logic        pred_taken;
    logic [4:0]  pred_index;
    logic [31:0] pred_target;
  } tag_t;

  typedef struct packed {
    tag_t        tag;
    logic [31:0] inst;
  } fs_ent_t;

  logic        started_q, started_d;
  logic        pred_ph_q, pred_ph_d;
  logic [31:0] p_q, p_d;
  logic [31:0] npc_q, npc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [1:0]  out_q, out_d;
  logic [1:0]  cancel_q, cancel_d;
  tag_t        tq_q [2];
  tag_t        tq_d [2];
  logic        tq_rd_q, tq_rd_d;
  logic        tq_wr_q, tq_wr_d;
  logic [1:0]  tq_cnt_q, tq_cnt_d;
  fs_ent_t     fq_q [2];
  fs_ent_t     fq_d [2];
  logic        fq_rd_q, fq_rd_d;
  logic        fq_wr_q, fq_wr_d;
  logic [1:0]  fq_cnt_q, fq_cnt_d;

  logic        req;
  logic        accept;
  logic        dok;
  logic        live;
  logic        drop;
  logic        tq_push;
  logic        fq_push;
  logic        fq_pop;
  logic        fsv;
  logic [31:0] pred_npc;
  logic [31:0] addr;
  tag_t        new_tag;
  tag_t        pop_tag;
  fs_ent_t     head;

  always_comb begin
    // data_ok with nothing outstanding belongs to a pre-reset request
    dok      = inst.inst_data_ok & (out_q != 2'd0);
    live     = dok & (cancel_q == 2'd0);
    drop     = dok & (cancel_q != 2'd0);
    pred_npc = (btb_ret_en & btb_taken) ? btb_ret_pc : p_q + 32'd4;
    new_tag  = '{pc: p_q,
                 pred_en: btb_ret_en,
                 pred_taken: btb_taken,
                 pred_index: btb_ret_index,
                 pred_target: btb_ret_pc};
    // zero-latency return pops the tag being written this cycle
    pop_tag  = (tq_cnt_q == 2'd0) ? new_tag : tq_q[tq_rd_q];
    req      = started_q & ~reset & ~redirect
             & (({1'b0, out_q} + {1'b0, fq_cnt_q}) < 3'd2);
    if (pend_q)
      addr = pend_pc_q;
    else if (pred_ph_q)
      addr = pred_npc;
    else
      addr = npc_q;
    accept   = req & inst.inst_addr_ok;
    head     = fq_q[fq_rd_q];
    fsv      = (fq_cnt_q != 2'd0) & ~reset;
    fq_pop   = fsv & ds_allowin;
    tq_push  = pred_ph_q & ~redirect;
    fq_push  = live & ~redirect;
  end

  always_comb begin
    started_d = 1'b1;
    pred_ph_d = accept;
    p_d       = accept ? addr : p_q;
    npc_d     = (pred_ph_q & ~redirect) ? pred_npc : npc_q;
    pend_d    = pend_q & ~accept;
    pend_pc_d = pend_pc_q;
    if (redirect) begin
      pend_d    = 1'b1;
      pend_pc_d = redirect_pc;
    end
    out_d    = out_q + {1'b0, accept} - {1'b0, dok};
    // every request still outstanding after a redirect is wrong-path
    cancel_d = redirect ? out_d : cancel_q - {1'b0, drop};

    tq_d     = tq_q;
    tq_rd_d  = tq_rd_q;
    tq_wr_d  = tq_wr_q;
    tq_cnt_d = tq_cnt_q;
    if (redirect) begin
      tq_rd_d  = 1'b0;
      tq_wr_d  = 1'b0;
      tq_cnt_d = 2'd0;
    end else begin
      if (tq_push && !(live && tq_cnt_q == 2'd0)) begin
        tq_d[tq_wr_q] = new_tag;
        tq_wr_d       = ~tq_wr_q;
      end
      if (live && tq_cnt_q != 2'd0)
        tq_rd_d = ~tq_rd_q;
      tq_cnt_d = tq_cnt_q + {1'b0, tq_push} - {1'b0, live};
    end

    fq_d     = fq_q;
    fq_rd_d  = fq_rd_q;
    fq_wr_d  = fq_wr_q;
    fq_cnt_d = fq_cnt_q;
    if (redirect) begin
      fq_rd_d  = 1'b0;
      fq_wr_d  = 1'b0;
      fq_cnt_d = 2'd0;
    end else begin
      if (fq_push) begin
        fq_d[fq_wr_q] = '{tag: pop_tag, inst: inst.inst_rdata};
        fq_wr_d       = ~fq_wr_q;
      end
      if (fq_pop)
        fq_rd_d = ~fq_rd_q;
      fq_cnt_d = fq_cnt_q + {1'b0, fq_push} - {1'b0, fq_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      started_q <= 1'b0;
      pred_ph_q <= 1'b0;
      p_q       <= '0;
      npc_q     <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      out_q     <= '0;
      cancel_q  <= '0;
      tq_rd_q   <= 1'b0;
      tq_wr_q   <= 1'b0;
      tq_cnt_q  <= '0;
      fq_rd_q   <= 1'b0;
      fq_wr_q   <= 1'b0;
      fq_cnt_q  <= '0;
    end else begin
      started_q <= started_d;
      pred_ph_q <= pred_ph_d;
      p_q       <= p_d;
      npc_q     <= npc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      out_q     <= out_d;
      cancel_q  <= cancel_d;
      tq_rd_q   <= tq_rd_d;
      tq_wr_q   <= tq_wr_d;
      tq_cnt_q  <= tq_cnt_d;
      fq_rd_q   <= fq_rd_d;
      fq_wr_q   <= fq_wr_d;
      fq_cnt_q  <= fq_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    tq_q <= tq_d;
    fq_q <= fq_d;
  end

  assign inst.inst_req   = req;
  assign inst.inst_addr  = addr;
  assign fetch_en        = accept;
  assign fetch_pc        = addr;
  assign fs_valid        = fsv;
  assign fs_pc           = head.tag.pc;
  assign fs_inst         = head.inst;
  assign fs_pred_en      = head.tag.pred_en;
  assign fs_pred_taken   = head.tag.pred_taken;
  assign fs_pred_index   = head.tag.pred_index;
  assign fs_pred_target  = head.tag.pred_target;

endmodule
